// File: rtl/data_sram_resp.sv
// data_sram_resp: responder end of the CPU data-SRAM interface.
// Word-addressed RAM plus an MMIO page (LED, SWITCH, TIMER, SCRATCH).
// Read data is registered, so it appears one cycle after the read edge.
// Optional macro DSRAM_ACCESS_CNT_EN adds the RDCNT/WRCNT access counters.
module data_sram_resp #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_F000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic [31:0] timer
);

  localparam int         DEPTH       = 1 << ADDR_W;
  localparam logic [11:0] OFF_LED     = 12'h000;
  localparam logic [11:0] OFF_SWITCH  = 12'h004;
  localparam logic [11:0] OFF_TIMER   = 12'h008;
  localparam logic [11:0] OFF_SCRATCH = 12'h00C;
`ifdef DSRAM_ACCESS_CNT_EN
  localparam logic [11:0] OFF_RDCNT   = 12'h010;
  localparam logic [11:0] OFF_WRCNT   = 12'h014;
`endif

  // Replace the byte lanes of old_v selected by be with the lanes of new_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0]       mem_q [DEPTH];
  logic [15:0]       led_q, led_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       scratch_q, scratch_d;
  logic [31:0]       rdata_q, rdata_d;
`ifdef DSRAM_ACCESS_CNT_EN
  logic [31:0]       rdcnt_q, rdcnt_d;
  logic [31:0]       wrcnt_q, wrcnt_d;
`endif

  logic              mmio_hit_s;
  logic [11:0]       off_s;
  logic [ADDR_W-1:0] widx_s;
  logic              rd_s;
  logic              wr_s;
  logic [31:0]       rd_mux_s;
  logic              unused_s;

  // Byte offset bits [1:0] never take part in decode (word accesses only).
  assign unused_s   = ^data_sram_addr[1:0];
  assign mmio_hit_s = (data_sram_addr[31:12] == MMIO_BASE[31:12]);
  assign off_s      = {data_sram_addr[11:2], 2'b00};
  assign widx_s     = data_sram_addr[ADDR_W+1:2];
  assign rd_s       = data_sram_en && (data_sram_wen == 4'b0000);
  assign wr_s       = data_sram_en && (data_sram_wen != 4'b0000);

  // Byte-enabled RAM write; the array itself is deliberately not reset.
  always_ff @(posedge clk) begin
    if (resetn && wr_s && !mmio_hit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          mem_q[widx_s][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Select the word a read at this edge returns (pre-update register values).
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    if (mmio_hit_s) begin
      case (off_s)
        OFF_LED:     rd_mux_s = {16'h0000, led_q};
        OFF_SWITCH:  rd_mux_s = {16'h0000, switch};
        OFF_TIMER:   rd_mux_s = timer_q;
        OFF_SCRATCH: rd_mux_s = scratch_q;
`ifdef DSRAM_ACCESS_CNT_EN
        OFF_RDCNT:   rd_mux_s = rdcnt_q;
        OFF_WRCNT:   rd_mux_s = wrcnt_q;
`endif
        default:     rd_mux_s = 32'h0000_0000;
      endcase
    end else begin
      rd_mux_s = mem_q[widx_s];
    end
  end

  // Next-state for MMIO registers, timer and read-data register.
  always_comb begin
    led_d     = led_q;
    scratch_d = scratch_q;
    timer_d   = timer_q + 32'd1;
    rdata_d   = rdata_q;
`ifdef DSRAM_ACCESS_CNT_EN
    rdcnt_d   = rdcnt_q;
    wrcnt_d   = wrcnt_q;
`endif
    if (rd_s) begin
      rdata_d = rd_mux_s;
`ifdef DSRAM_ACCESS_CNT_EN
      rdcnt_d = rdcnt_q + 32'd1;
`endif
    end else begin
      rdata_d = rdata_q;
    end
    if (wr_s && mmio_hit_s) begin
      case (off_s)
        OFF_LED: begin
          led_d[7:0]  = data_sram_wen[0] ? data_sram_wdata[7:0]  : led_q[7:0];
          led_d[15:8] = data_sram_wen[1] ? data_sram_wdata[15:8] : led_q[15:8];
        end
        OFF_TIMER:   timer_d   = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
        OFF_SCRATCH: scratch_d = byte_merge(scratch_q, data_sram_wdata, data_sram_wen);
        default: begin
          led_d     = led_q;
          scratch_d = scratch_q;
        end
      endcase
    end else begin
      led_d     = led_q;
      scratch_d = scratch_q;
    end
`ifdef DSRAM_ACCESS_CNT_EN
    if (wr_s) begin
      wrcnt_d = wrcnt_q + 32'd1;
    end else begin
      wrcnt_d = wrcnt_q;
    end
`endif
  end

  // State registers with synchronous active-low reset; reset drops any access.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led_q     <= 16'h0000;
      timer_q   <= 32'h0000_0000;
      scratch_q <= 32'h0000_0000;
      rdata_q   <= 32'h0000_0000;
`ifdef DSRAM_ACCESS_CNT_EN
      rdcnt_q   <= 32'h0000_0000;
      wrcnt_q   <= 32'h0000_0000;
`endif
    end else begin
      led_q     <= led_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
`ifdef DSRAM_ACCESS_CNT_EN
      rdcnt_q   <= rdcnt_d;
      wrcnt_q   <= wrcnt_d;
`endif
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign timer           = timer_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Testbench for data_sram_resp: directed scenarios followed by random traffic,
// checked every cycle against a behavioural model of RAM + MMIO page.
module tb_data_sram_resp;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] switch;
  logic [15:0] led;
  logic [31:0] timer;

  int n_vec;
  int n_err;

  // reference model state
  logic [31:0] ram_m [0:1023];
  logic [31:0] m_rdata, m_timer, m_scratch, m_rdcnt, m_wrcnt;
  logic [15:0] m_led;

  data_sram_resp dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch          (switch),
    .led             (led),
    .timer           (timer)
  );

  // free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [11:0] off;
    off = {a[11:2], 2'b00};
    if (a[31:12] != 20'hBFAFF) return ram_m[a[11:2]];
    case (off)
      12'h000: return {16'h0000, m_led};
      12'h004: return {16'h0000, switch};
      12'h008: return m_timer;
      12'h00C: return m_scratch;
`ifdef DSRAM_ACCESS_CNT_EN
      12'h010: return m_rdcnt;
      12'h014: return m_wrcnt;
`endif
      default: return 32'h0000_0000;
    endcase
  endfunction

  // one clock edge: drive, let the edge happen, advance the model, compare
  task automatic step(input logic rn, input logic en, input logic [3:0] wen,
                      input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] nt;
    logic [11:0] off;
    resetn = rn; data_sram_en = en; data_sram_wen = wen;
    data_sram_addr = a; data_sram_wdata = wd;
    @(posedge clk);
    if (!rn) begin
      m_rdata = 32'h0; m_led = 16'h0; m_timer = 32'h0; m_scratch = 32'h0;
      m_rdcnt = 32'h0; m_wrcnt = 32'h0;
    end else begin
      nt  = m_timer + 32'd1;
      off = {a[11:2], 2'b00};
      if (en && wen == 4'b0000) begin
        m_rdata = ref_read(a);
        m_rdcnt = m_rdcnt + 32'd1;
      end
      if (en && wen != 4'b0000) begin
        m_wrcnt = m_wrcnt + 32'd1;
        if (a[31:12] != 20'hBFAFF) ram_m[a[11:2]] = merge(ram_m[a[11:2]], wd, wen);
        else if (off == 12'h000) m_led = merge({16'h0000, m_led}, wd, {2'b00, wen[1:0]}) & 32'h0000_FFFF;
        else if (off == 12'h008) nt = merge(m_timer, wd, wen);
        else if (off == 12'h00C) m_scratch = merge(m_scratch, wd, wen);
      end
      m_timer = nt;
    end
    #1;
    chk("rdata", data_sram_rdata, m_rdata);
    chk("led", {16'h0000, led}, {16'h0000, m_led});
    chk("timer", timer, m_timer);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  logic [31:0] held;

  initial begin
    n_vec = 0; n_err = 0;
    resetn = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'h0;
    data_sram_addr = 32'h0; data_sram_wdata = 32'h0; switch = 16'h0000;
    m_rdata = 32'h0; m_led = 16'h0; m_timer = 32'h0; m_scratch = 32'h0;
    m_rdcnt = 32'h0; m_wrcnt = 32'h0;
    #2;

    // reset, including a dropped write to LED during reset
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 4'hF, 32'hBFAF_F000, 32'hFFFF_FFFF);
    chk("rst_led", {16'h0000, led}, 32'h0);
    chk("rst_rdata", data_sram_rdata, 32'h0);

    // timer counts from release
    idle(10);
    chk("timer10", timer, 32'd10);

    // fill RAM so the model knows every word
    for (int i = 0; i < 1024; i++)
      step(1'b1, 1'b1, 4'hF, i << 2, $urandom);

    // full-word write then read
    step(1'b1, 1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 4'h0, 32'h0000_0040, 32'h0);
    chk("ram_rd", data_sram_rdata, 32'hDEAD_BEEF);

    // partial byte write
    step(1'b1, 1'b1, 4'hF, 32'h0000_0080, 32'h1122_3344);
    step(1'b1, 1'b1, 4'b0101, 32'h0000_0080, 32'hAABB_CCDD);
    step(1'b1, 1'b1, 4'h0, 32'h0000_0080, 32'h0);
    chk("ram_part", data_sram_rdata, 32'h11BB_33DD);

    // LED and SWITCH
    step(1'b1, 1'b1, 4'hF, 32'hBFAF_F000, 32'hFFFF_A5A5);
    chk("led_wr", {16'h0000, led}, 32'h0000_A5A5);
    step(1'b1, 1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
    chk("led_rd", data_sram_rdata, 32'h0000_A5A5);
    switch = 16'h00F0;
    step(1'b1, 1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
    chk("sw_rd", data_sram_rdata, 32'h0000_00F0);

    // timer load and wrap
    step(1'b1, 1'b1, 4'hF, 32'hBFAF_F008, 32'hFFFF_FFFE);
    chk("tmr_ld", timer, 32'hFFFF_FFFE);
    idle(1);
    chk("tmr_max", timer, 32'hFFFF_FFFF);
    idle(1);
    chk("tmr_wrap", timer, 32'h0);

    // back-to-back write/read then hold across idle cycles
    step(1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'h5A5A_1234);
    step(1'b1, 1'b1, 4'h0, 32'h0000_0100, 32'h0);
    chk("b2b", data_sram_rdata, 32'h5A5A_1234);
    idle(3);
    chk("hold", data_sram_rdata, 32'h5A5A_1234);

    // aliasing: upper address bits ignored
    step(1'b1, 1'b1, 4'h0, 32'h8000_1100, 32'h0);
    chk("alias", data_sram_rdata, 32'h5A5A_1234);

    // SCRATCH write, then reset coincident with a write
    step(1'b1, 1'b1, 4'hF, 32'hBFAF_F00C, 32'hCAFE_F00D);
    step(1'b1, 1'b1, 4'h0, 32'hBFAF_F00C, 32'h0);
    chk("scr_rd", data_sram_rdata, 32'hCAFE_F00D);
    step(1'b0, 1'b1, 4'hF, 32'hBFAF_F00C, 32'h1234_5678);
    step(1'b1, 1'b1, 4'h0, 32'hBFAF_F00C, 32'h0);
    chk("scr_rst", data_sram_rdata, 32'h0);

    // unmapped offset reads zero, write there is ignored
    step(1'b1, 1'b1, 4'hF, 32'hBFAF_F020, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    chk("unmap", data_sram_rdata, 32'h0);

    // access counters: fresh reset, 3 reads + 2 writes
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 4'h0, 32'h0000_0000, 32'h0);
    step(1'b1, 1'b1, 4'h0, 32'h0000_0004, 32'h0);
    step(1'b1, 1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
    step(1'b1, 1'b1, 4'hF, 32'h0000_0200, 32'h0BAD_CAFE);
    step(1'b1, 1'b1, 4'h3, 32'hBFAF_F00C, 32'h0000_7777);
    step(1'b1, 1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
`ifdef DSRAM_ACCESS_CNT_EN
    chk("rdcnt", data_sram_rdata, 32'd3);
`else
    chk("rdcnt_off", data_sram_rdata, 32'd0);
`endif
    step(1'b1, 1'b1, 4'hF, 32'hBFAF_F014, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 4'h0, 32'hBFAF_F014, 32'h0);
`ifdef DSRAM_ACCESS_CNT_EN
    chk("wrcnt", data_sram_rdata, 32'd3);
`else
    chk("wrcnt_off", data_sram_rdata, 32'd0);
`endif

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [3:0]  w;
      int          sel;
      sel = $urandom_range(0, 3);
      if (sel < 2)       a = $urandom;
      else if (sel == 2) a = 32'hBFAF_F000 | ($urandom_range(0, 7) << 2);
      else               a = 32'hBFAF_F000 | ($urandom & 32'h0000_0FFF);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      switch = 16'($urandom);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) != 0), w, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
